// File: rtl/aes_pcm_pkg.sv
// Shared widths, the buffered block record and the PCM byte-swap helper
// for the AES block to PCM word unpacker.
package aes_pcm_pkg;

    localparam int BLOCK_W         = 128;
    localparam int WORD_W          = 32;
    localparam int WORDS_PER_BLOCK = 4;

    typedef struct packed {
        logic [BLOCK_W-1:0] data;
        logic               last;
    } aes_blk_t;

    function automatic logic [WORD_W-1:0] byte_swap32(input logic [WORD_W-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// DEPTH-entry buffer of decrypted AES blocks with occupancy count.
// Entries are not cleared on reset/flush; only pointers and count are.
module aes_blk_fifo
    import aes_pcm_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             push,
    input  aes_blk_t         push_blk,
    input  logic             pop,
    output aes_blk_t         head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    aes_blk_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full & ~clear;
    assign do_pop  = pop & ~empty & ~clear;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_blk;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/aes_block_pcm_unpacker.sv
// Buffers decrypted 128-bit AES blocks and emits each as four 32-bit
// stereo PCM words, counting sink underruns once the stream has started.
module aes_block_pcm_unpacker
    import aes_pcm_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter bit BYTE_SWAP = 1'b0,
    parameter int UNDER_W   = 16
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic                   flush,
    input  logic [BLOCK_W-1:0]     s_block_tdata,
    input  logic                   s_block_tlast,
    input  logic                   s_block_tvalid,
    output logic                   s_block_tready,
    output logic [WORD_W-1:0]      m_pcm_tdata,
    output logic                   m_pcm_tlast,
    output logic                   m_pcm_tvalid,
    input  logic                   m_pcm_tready,
    output logic [$clog2(DEPTH):0] level,
    output logic [UNDER_W-1:0]     underrun_cnt
);

    localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);

    logic                   clear;
    aes_blk_t               in_blk;
    aes_blk_t               head;
    logic [$clog2(DEPTH):0] count;
    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   pop_word;
    logic                   pop_block;
    logic [IDX_W-1:0]       word_idx;
    logic                   primed;
    logic [WORD_W-1:0]      raw_word;
    logic [WORD_W-1:0]      word;
    logic [WORD_W-1:0]      held_data;

    assign clear          = ARESET | flush;
    assign in_blk         = {s_block_tdata, s_block_tlast};
    assign s_block_tready = ~full & ~clear;
    assign push           = s_block_tvalid & s_block_tready;
    assign m_pcm_tvalid   = ~empty;
    assign pop_word       = m_pcm_tvalid & m_pcm_tready;
    assign pop_block      = pop_word & (word_idx == LAST_IDX);
    assign level          = count;

    aes_blk_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (ACLK),
        .clear    (clear),
        .push     (push),
        .push_blk (in_blk),
        .pop      (pop_block),
        .head     (head),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    // Word 0 is the most significant slice of the block (byte 0 first).
    always_comb begin
        raw_word = '0;
        case (word_idx)
            2'd0:    raw_word = head.data[127:96];
            2'd1:    raw_word = head.data[95:64];
            2'd2:    raw_word = head.data[63:32];
            default: raw_word = head.data[31:0];
        endcase
        word = BYTE_SWAP ? byte_swap32(raw_word) : raw_word;
    end

    assign m_pcm_tdata = m_pcm_tvalid ? word : held_data;
    assign m_pcm_tlast = m_pcm_tvalid & head.last & (word_idx == LAST_IDX);

    always_ff @(posedge ACLK) begin
        if (clear) begin
            word_idx  <= '0;
            held_data <= '0;
        end else if (pop_word) begin
            word_idx  <= pop_block ? '0 : word_idx + 1'b1;
            held_data <= word;
        end
    end

    // Underruns only count once a stream has started after reset/flush.
    always_ff @(posedge ACLK) begin
        if (clear) begin
            primed       <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            if (push) begin
                primed <= 1'b1;
            end
            if (primed && m_pcm_tready && !m_pcm_tvalid && !(&underrun_cnt)) begin
                underrun_cnt <= underrun_cnt + 1'b1;
            end
        end
    end

endmodule
